// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: instruction ids,
// FSM state encoding and small decode helpers.
package lsu_pkg;

   localparam logic [5:0] LB  = 6'h0B;
   localparam logic [5:0] LH  = 6'h0C;
   localparam logic [5:0] LW  = 6'h0D;
   localparam logic [5:0] LBU = 6'h0E;
   localparam logic [5:0] LHU = 6'h0F;
   localparam logic [5:0] SB  = 6'h10;
   localparam logic [5:0] SH  = 6'h11;
   localparam logic [5:0] SW  = 6'h12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   function automatic logic lsu_is_mem(input logic [5:0] id);
      return id inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
   endfunction

   function automatic logic lsu_is_store(input logic [5:0] id);
      return id inside {SB, SH, SW};
   endfunction

   // Half access needs addr[0]=0, word access needs addr[1:0]=0.
   function automatic logic lsu_is_misaligned(
      input logic [5:0] id,
      input logic [1:0] off
   );
      logic half;
      logic word;
      half = id inside {LH, LHU, SH};
      word = id inside {LW, SW};
      return (half & off[0]) | (word & (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data formatting: load byte/half extract with sign/zero
// extension, store lane replication and byte-enable generation.
// Ports: op_id, byte_off (addr[1:0]), store_data, rdata in;
//        load_data, wdata, be out.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [5:0]  op_id,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [31:0] load_data,
   output logic [31:0] wdata,
   output logic [3:0]  be
);

   logic [31:0] shifted;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      shifted   = rdata >> {byte_off, 3'b000};
      lane_byte = shifted[7:0];
      lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data = rdata;
      case (op_id)
         LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
         LBU:     load_data = {24'h0, lane_byte};
         LH:      load_data = {{16{lane_half[15]}}, lane_half};
         LHU:     load_data = {16'h0, lane_half};
         default: load_data = rdata;
      endcase
   end

   // Loads and SW fall through to the full-word default.
   always_comb begin
      wdata = store_data;
      be    = 4'hF;
      case (op_id)
         SB: begin
            wdata = {4{store_data[7:0]}};
            be    = 4'b0001 << byte_off;
         end
         SH: begin
            wdata = {2{store_data[15:0]}};
            be    = byte_off[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one valid/ready data-memory transaction per
// load/store from EX_MEM, formats load data and stalls the pipeline.
// Ports: clk, rst (async, active-high); valid_in, instr_id_in, addr_in,
//        store_data_in from EX_MEM; lsu_stall, mem_data_out, mem_done to
//        pipeline/MEM_WB; dmem_req_* / dmem_resp_* to data memory.
// Optional: LSU_MISALIGN_TRAP_EN adds misalign_out and skips the memory
//           request for misaligned half/word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [5:0]        instr_id_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] store_data_in,
   output logic              lsu_stall,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_done,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic              misalign_out,
`endif
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_we,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [DATA_W-1:0] dmem_req_wdata,
   output logic [3:0]        dmem_req_be,
   input  logic              dmem_resp_valid,
   input  logic [DATA_W-1:0] dmem_resp_rdata
);

   lsu_state_t        state;
   lsu_state_t        state_next;
   logic [5:0]        op_id;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data;
   logic              start;
   logic              mis_in;
   logic [31:0]       fmt_load;
   logic [31:0]       fmt_wdata;
   logic [3:0]        fmt_be;

   assign start = valid_in & lsu_is_mem(instr_id_in);

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;
   assign mis_in = lsu_is_misaligned(instr_id_in, addr_in[1:0]);
   assign misalign_out = (state == DONE) & mis_q;
`else
   assign mis_in = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = mis_in ? DONE : REQ;
         REQ: if (dmem_req_ready)
            state_next = lsu_is_store(op_id) ? DONE : WAIT;
         WAIT: if (dmem_resp_valid) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      lsu_stall      = 1'b0;
      dmem_req_valid = 1'b0;
      mem_done       = 1'b0;
      unique case (state)
         IDLE: lsu_stall = start;
         REQ: begin
            lsu_stall      = 1'b1;
            dmem_req_valid = 1'b1;
         end
         WAIT: lsu_stall = 1'b1;
         DONE: mem_done  = 1'b1;
         default: ;
      endcase
   end

   // Request fields are zero outside REQ so reset leaves the port quiet.
   always_comb begin
      dmem_req_we    = 1'b0;
      dmem_req_addr  = '0;
      dmem_req_wdata = '0;
      dmem_req_be    = 4'h0;
      if (dmem_req_valid) begin
         dmem_req_we    = lsu_is_store(op_id);
         dmem_req_addr  = {op_addr[ADDR_W-1:2], 2'b00};
         dmem_req_wdata = fmt_wdata;
         dmem_req_be    = fmt_be;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_id        <= '0;
         op_addr      <= '0;
         op_data      <= '0;
         mem_data_out <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q        <= 1'b0;
`endif
      end else begin
         if (state == IDLE && start) begin
            op_id   <= instr_id_in;
            op_addr <= addr_in;
            op_data <= store_data_in;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_in;
`endif
         end
         if (state == WAIT && dmem_resp_valid)
            mem_data_out <= fmt_load;
      end
   end

   lsu_data_align u_align (
      .op_id      (op_id),
      .byte_off   (op_addr[1:0]),
      .store_data (op_data),
      .rdata      (dmem_resp_rdata),
      .load_data  (fmt_load),
      .wdata      (fmt_wdata),
      .be         (fmt_be)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model,
// per-cycle compare process and directed vectors with literal results.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 0;
   logic        rst = 1;
   logic        valid_in = 0;
   logic [5:0]  instr_id_in = 0;
   logic [31:0] addr_in = 0;
   logic [31:0] store_data_in = 0;
   logic        lsu_stall;
   logic [31:0] mem_data_out;
   logic        mem_done;
   logic        dmem_req_valid;
   logic        dmem_req_ready = 1;
   logic        dmem_req_we;
   logic [31:0] dmem_req_addr;
   logic [31:0] dmem_req_wdata;
   logic [3:0]  dmem_req_be;
   logic        dmem_resp_valid = 0;
   logic [31:0] dmem_resp_rdata = 0;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign_out;
`endif

   int total = 0;
   int bad = 0;

   load_store_unit dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .instr_id_in     (instr_id_in),
      .addr_in         (addr_in),
      .store_data_in   (store_data_in),
      .lsu_stall       (lsu_stall),
      .mem_data_out    (mem_data_out),
      .mem_done        (mem_done),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign_out    (misalign_out),
`endif
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_req_we     (dmem_req_we),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_wdata  (dmem_req_wdata),
      .dmem_req_be     (dmem_req_be),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_rdata (dmem_resp_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic bit m_mem(input logic [5:0] id);
      return id == LB || id == LH || id == LW || id == LBU ||
             id == LHU || id == SB || id == SH || id == SW;
   endfunction

   function automatic bit m_st(input logic [5:0] id);
      return id == SB || id == SH || id == SW;
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] id,
                                          input int k,
                                          input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * k)) & 32'hFF;
      h = (w >> (16 * (k / 2))) & 32'hFFFF;
      if (id == LB)  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      if (id == LBU) return b;
      if (id == LH)  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      if (id == LHU) return h;
      return w;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [5:0] id,
                                           input logic [31:0] d);
      if (id == SB) return (d & 32'hFF) * 32'h01010101;
      if (id == SH) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] m_be(input logic [5:0] id, input int k);
      if (id == SB) return 4'(1 << k);
      if (id == SH) return (k >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic bit m_misal(input logic [5:0] id, input int k);
`ifdef LSU_MISALIGN_TRAP_EN
      if (id == LH || id == LHU || id == SH) return (k % 2) != 0;
      if (id == LW || id == SW) return k != 0;
`endif
      return 0;
   endfunction

   // ---------------- transaction model ----------------
   bit          m_have, m_sent, m_fin, m_mis;
   logic [5:0]  m_id;
   logic [31:0] m_addr, m_sd, m_data;
   bit          chk_en = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_have = 0; m_sent = 0; m_fin = 0; m_mis = 0;
         m_data = 0; m_id = 0; m_addr = 0; m_sd = 0;
      end else if (m_fin) begin
         m_fin = 0; m_have = 0; m_mis = 0;
      end else if (!m_have) begin
         if (valid_in && m_mem(instr_id_in)) begin
            m_have = 1; m_sent = 0;
            m_id = instr_id_in; m_addr = addr_in; m_sd = store_data_in;
            if (m_misal(m_id, int'(m_addr % 4))) begin
               m_mis = 1; m_fin = 1;
            end
         end
      end else if (!m_sent) begin
         if (dmem_req_ready) begin
            m_sent = 1;
            if (m_st(m_id)) m_fin = 1;
         end
      end else if (dmem_resp_valid) begin
         m_data = m_load(m_id, int'(m_addr % 4), dmem_resp_rdata);
         m_fin = 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         bit e_req;
         bit e_stall;
         e_req = m_have && !m_sent && !m_fin;
         e_stall = (!m_have && valid_in && m_mem(instr_id_in)) ||
                   (m_have && !m_fin);
         chk("cyc_stall", 32'(lsu_stall), 32'(e_stall));
         chk("cyc_req_valid", 32'(dmem_req_valid), 32'(e_req));
         chk("cyc_done", 32'(mem_done), 32'(m_fin));
         chk("cyc_data", mem_data_out, m_data);
`ifdef LSU_MISALIGN_TRAP_EN
         chk("cyc_misalign", 32'(misalign_out), 32'(m_fin && m_mis));
`endif
         if (e_req) begin
            int k;
            k = int'(m_addr % 4);
            chk("cyc_addr", dmem_req_addr, m_addr - (m_addr % 4));
            chk("cyc_we", 32'(dmem_req_we), 32'(m_st(m_id)));
            if (m_st(m_id))
               chk("cyc_wdata", dmem_req_wdata, m_wdata(m_id, m_sd));
            chk("cyc_be", 32'(dmem_req_be), 32'(m_be(m_id, k)));
         end
      end
   end

   // ---------------- memory responder ----------------
   logic [31:0] mem_word = 0;
   int          ready_delay = 0;
   int          age = 0;
   bit          hs_load = 0;
   bit          resp_en = 1;
   bit          inj_valid = 0;
   logic [31:0] inj_data = 0;

   always @(negedge clk) begin
      hs_load = dmem_req_valid && dmem_req_ready && !dmem_req_we && resp_en;
      if (dmem_req_valid) age++;
      else age = 0;
   end

   always @(posedge clk) begin
      #1;
      dmem_resp_valid = hs_load || inj_valid;
      dmem_resp_rdata = inj_valid ? inj_data : (hs_load ? mem_word : 32'h0);
      dmem_req_ready = (age >= ready_delay);
   end

   // ---------------- driver ----------------
   int          o_stalls, o_reqs, o_unst;
   logic [31:0] o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_we, o_mis;

   task automatic do_op(input logic [5:0] id, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] w);
      bit got;
      got = 0;
      mem_word = w;
      valid_in = 1; instr_id_in = id; addr_in = a; store_data_in = sd;
      o_stalls = 0; o_reqs = 0; o_unst = 0; o_mis = 0;
      o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (lsu_stall) o_stalls++;
         if (dmem_req_valid) begin
            if (o_reqs == 0) begin
               o_addr = dmem_req_addr; o_wdata = dmem_req_wdata;
               o_be = dmem_req_be; o_we = dmem_req_we;
            end else if (dmem_req_addr != o_addr ||
                         dmem_req_wdata != o_wdata ||
                         dmem_req_be != o_be || dmem_req_we != o_we) begin
               o_unst++;
            end
            o_reqs++;
         end
         if (mem_done) begin
            got = 1;
`ifdef LSU_MISALIGN_TRAP_EN
            o_mis = misalign_out;
`endif
         end
         @(posedge clk); #1;
         if (got) break;
      end
      valid_in = 0; instr_id_in = 0;
      chk("done_seen", 32'(got), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(lsu_stall), 0);
      chk("rst_done", 32'(mem_done), 0);
      chk("rst_req", 32'(dmem_req_valid), 0);
      chk("rst_data", mem_data_out, 0);
      rst = 0;
      chk_en = 1;
      @(posedge clk); #1;

      do_op(LW, 32'h100, 0, 32'hDEADBEEF);
      chk("lw_addr", o_addr, 32'h100);
      chk("lw_be", 32'(o_be), 32'hF);
      chk("lw_we", 32'(o_we), 0);
      chk("lw_stall", o_stalls, 3);
      chk("lw_data", mem_data_out, 32'hDEADBEEF);

      do_op(LB, 32'h203, 0, 32'h80FF1234);
      chk("lb_addr", o_addr, 32'h200);
      chk("lb_data", mem_data_out, 32'hFFFFFF80);
      do_op(LBU, 32'h203, 0, 32'h80FF1234);
      chk("lbu_data", mem_data_out, 32'h00000080);

      valid_in = 1; instr_id_in = 6'h01; addr_in = 32'h900;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nonmem_stall", 32'(lsu_stall), 0);
         chk("nonmem_req", 32'(dmem_req_valid), 0);
         @(posedge clk); #1;
      end
      valid_in = 0; instr_id_in = 0;
      chk("nonmem_hold", mem_data_out, 32'h00000080);

      do_op(SH, 32'h302, 32'h0000ABCD, 0);
      chk("sh_we", 32'(o_we), 1);
      chk("sh_addr", o_addr, 32'h300);
      chk("sh_wdata", o_wdata, 32'hABCDABCD);
      chk("sh_be", 32'(o_be), 32'hC);
      chk("sh_stall", o_stalls, 2);
      chk("sh_data_hold", mem_data_out, 32'h00000080);

      do_op(SB, 32'h501, 32'h1234565A, 0);
      chk("sb_wdata", o_wdata, 32'h5A5A5A5A);
      chk("sb_be", 32'(o_be), 32'h2);

      do_op(SW, 32'h604, 32'hCAFEF00D, 0);
      chk("sw_wdata", o_wdata, 32'hCAFEF00D);
      chk("sw_be", 32'(o_be), 32'hF);

      do_op(LH, 32'h400, 0, 32'h80017FFF);
      chk("lh0_data", mem_data_out, 32'h00007FFF);
      do_op(LH, 32'h402, 0, 32'h80017FFF);
      chk("lh2_data", mem_data_out, 32'hFFFF8001);
      do_op(LHU, 32'h402, 0, 32'h80017FFF);
      chk("lhu_data", mem_data_out, 32'h00008001);

      ready_delay = 5;
      do_op(LW, 32'h800, 0, 32'h0BADF00D);
      ready_delay = 0;
      chk("rdy_stall", o_stalls, 8);
      chk("rdy_reqs", o_reqs, 6);
      chk("rdy_stable", o_unst, 0);
      chk("rdy_data", mem_data_out, 32'h0BADF00D);

`ifdef LSU_MISALIGN_TRAP_EN
      do_op(LW, 32'h101, 0, 32'h11223344);
      chk("mis_lw_reqs", o_reqs, 0);
      chk("mis_lw_flag", 32'(o_mis), 1);
      chk("mis_lw_stall", o_stalls, 1);
      chk("mis_lw_data", mem_data_out, 32'h0BADF00D);
      do_op(SH, 32'h303, 32'h1111, 0);
      chk("mis_sh_reqs", o_reqs, 0);
      chk("mis_sh_flag", 32'(o_mis), 1);
`else
      do_op(LW, 32'h102, 0, 32'h11223344);
      chk("al_lw_addr", o_addr, 32'h100);
      chk("al_lw_data", mem_data_out, 32'h11223344);
      do_op(SW, 32'h607, 32'h55667788, 0);
      chk("al_sw_addr", o_addr, 32'h604);
      chk("al_sw_be", 32'(o_be), 32'hF);
`endif

      resp_en = 0;
      valid_in = 1; instr_id_in = LW; addr_in = 32'h700;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_stall", 32'(lsu_stall), 1);
      chk("wait_req", 32'(dmem_req_valid), 0);
      rst = 1;
      valid_in = 0; instr_id_in = 0;
      #1;
      chk("mid_rst_stall", 32'(lsu_stall), 0);
      chk("mid_rst_req", 32'(dmem_req_valid), 0);
      chk("mid_rst_done", 32'(mem_done), 0);
      chk("mid_rst_data", mem_data_out, 0);
      chk("mid_rst_addr", dmem_req_addr, 0);
      chk("mid_rst_be", 32'(dmem_req_be), 0);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      inj_valid = 1; inj_data = 32'h12345678;
      @(negedge clk);
      inj_valid = 0;
      chk("late_resp_seen", 32'(dmem_resp_valid), 1);
      @(negedge clk);
      chk("late_data", mem_data_out, 0);
      chk("late_done", 32'(mem_done), 0);
      chk("late_stall", 32'(lsu_stall), 0);
      resp_en = 1;
      @(posedge clk); #1;

      do_op(LBU, 32'h001, 0, 32'h0000A500);
      chk("post_rst_data", mem_data_out, 32'h000000A5);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage logic between EX_MEM and MEM_WB.
- Takes a decoded load/store from EX_MEM and runs a valid/ready request/response transaction on the data-memory port.
- Formats load data (byte/half extraction, sign/zero extension) and generates store byte-enables.
- Drives a stall that gates the enable of upstream pipeline registers and MEM_WB.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  EX_MEM slot holds a live instruction
- instr_id_in  in  6  decoded instruction id (codes from package)
- addr_in  in  ADDR_W  effective byte address (EX result)
- store_data_in  in  32  rs2 value for stores
- lsu_stall  out  1  hold pipeline; MEM_WB enable = !lsu_stall
- mem_data_out  out  32  formatted load data, feeds MEM_WB mem_data_in
- mem_done  out  1  one-cycle pulse, memory op complete
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1=store
- dmem_req_addr  out  ADDR_W  word-aligned address ([1:0]=0)
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_resp_valid  in  1  load response valid
- dmem_resp_rdata  in  32  raw word read

Behaviour:
- Reset: state=IDLE; all outputs 0; latched op/addr/data cleared. Reset mid-transaction abandons the request; nothing is retried.
- is_mem = instr_id_in in {LB,LH,LW,LBU,LHU,SB,SH,SW}.
- lsu_stall = (IDLE & valid_in & is_mem) | REQ | WAIT. Combinational; low in DONE so the pipeline advances at the end of DONE.
- IDLE:
  - valid_in & is_mem: latch id, addr, store data; -> REQ.
  - Otherwise stay in IDLE; mem_data_out holds.
- REQ:
  - dmem_req_valid=1; req fields stable from registers until accepted.
  - On ready: store -> DONE; load -> WAIT.
- WAIT:
  - dmem_req_valid=0.
  - On resp_valid: register the formatted data into mem_data_out; -> DONE.
  - Response arriving in any other state is ignored.
- DONE: mem_done=1 for one cycle; -> IDLE. The next instruction is sampled only in the following IDLE cycle, so an op is never accepted twice.
- Minimum stall with ready=1 and response next cycle:
  - Load: 3 cycles (IDLE, REQ, WAIT), DONE on the 4th.
  - Store: 2 cycles.
- Load formatting (k=addr[1:0]):
  - LB/LBU: byte k, sign/zero extended.
  - LH/LHU: half addr[1], sign/zero extended.
  - LW: full word.
- Store formatting:
  - SB: wdata={4{byte}}, be=4'b0001<<k.
  - SH: wdata={2{half}}, be=4'b0011<<(2*addr[1]).
  - SW: be=4'hF.
- Loads drive be=4'hF, we=0.
- Without MISALIGN_TRAP_EN, misaligned low address bits are ignored: LH/SH use addr[1] only; LW/SW ignore [1:0].

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Adds output misalign_out (1 bit).
  - Misaligned op (half with addr[0]=1, word with addr[1:0]!=0) issues no request.
  - IDLE -> DONE directly (stall high for 1 cycle); misalign_out=1 with mem_done in DONE.
  - mem_data_out unchanged.
- LSU_MISALIGN_TRAP_EN undefined: no port; silent-alignment rules above apply.

Decomposition:
- Package lsu_pkg: 6-bit instr id constants:
  - LB=6'h0B, LH=6'h0C, LW=6'h0D, LBU=6'h0E, LHU=6'h0F
  - SB=6'h10, SH=6'h11, SW=6'h12
- Also in lsu_pkg: FSM state encoding IDLE/REQ/WAIT/DONE (2-bit).
- One sub-module: lsu_data_align. Purely combinational load extract/extend plus store lane replication and byte-enable generation.

Test Plan:
- LW addr 0x100, ready=1, resp next cycle rdata 0xDEADBEEF -> req_addr=0x100, be=F; stall high 3 cycles; mem_data_out=0xDEADBEEF; mem_done pulse.
- LB addr 0x203, rdata 0x80FF1234 -> mem_data_out=0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x302, data 0x0000ABCD -> we=1, req_addr=0x300, wdata=0xABCDABCD, be=4'b1100; stall 2 cycles; no response awaited.
- ready held low 5 cycles in REQ -> req fields stable, stall stays high; completes after ready rises.
- rst asserted while in WAIT -> next cycle state IDLE, all outputs 0; late resp_valid ignored.
- Non-memory instr (id 6'h01), valid_in=1 -> stall=0, no request, mem_data_out held.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x101 -> no dmem_req_valid; misalign_out=1 and mem_done=1 in the same cycle.
